// File: rtl/vdp_super_palette_pkg.sv
// Shared types and constants for the super-resolution palette path.
// Shared by the palette RAM, the sequencer top level and the bus interface.
package vdp_super_pkg;

    localparam int PALETTE_ENTRIES = 256;
    localparam int PALETTE_AW      = $clog2(PALETTE_ENTRIES);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } palette_rgb_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE_R,
        WAIT_G,
        WAIT_B
    } palette_wr_state_t;

    // Power-up contents of entry idx: a grey ramp, or black when the ramp is disabled.
    function automatic palette_rgb_t init_colour(input logic [PALETTE_AW-1:0] idx, input bit ramp);
        palette_rgb_t c;
        c = '0;
        if (ramp) begin
            c = palette_rgb_t'{r: idx, g: idx, b: idx};
        end
        return c;
    endfunction

endpackage

// File: rtl/vdp_super_palette_if.sv
// Renderer lookup port and CPU palette-write port of the palette store.
// The master side is the renderer/CPU; the slave side is the palette.
interface vdp_super_palette_if;
    import vdp_super_pkg::*;

    logic [PALETTE_AW-1:0] palette_addr;
    logic [7:0]            palette_r;
    logic [7:0]            palette_g;
    logic [7:0]            palette_b;
    logic                  cpu_index_wr;
    logic                  cpu_data_wr;
    logic [7:0]            cpu_data;
    logic [PALETTE_AW-1:0] cpu_index;
    logic                  init_busy;

    modport master (
        output palette_addr,
        output cpu_index_wr,
        output cpu_data_wr,
        output cpu_data,
        input  palette_r,
        input  palette_g,
        input  palette_b,
        input  cpu_index,
        input  init_busy
    );

    modport slave (
        input  palette_addr,
        input  cpu_index_wr,
        input  cpu_data_wr,
        input  cpu_data,
        output palette_r,
        output palette_g,
        output palette_b,
        output cpu_index,
        output init_busy
    );

endinterface

// File: rtl/vdp_palette_ram.sv
// Simple dual-port palette RAM: one synchronous write port, one registered read port.
// The read register samples the old contents when both ports hit the same address.
module vdp_palette_ram
    import vdp_super_pkg::*;
#(
    parameter int DEPTH = PALETTE_ENTRIES,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [AW-1:0] i_waddr,
    input  palette_rgb_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output palette_rgb_t o_rdata
);

    palette_rgb_t r_mem [DEPTH];
    palette_rgb_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vdp_super_palette.sv
// Palette store with CPU index-then-R/G/B write sequencer and power-up self-initialisation.
// Renderer lookups have one clock of latency and are never stalled by writes.
module vdp_super_palette
    import vdp_super_pkg::*;
#(
    parameter int ENTRIES   = PALETTE_ENTRIES,
    parameter bit INIT_RAMP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    vdp_super_palette_if.slave bus
);

    localparam logic [PALETTE_AW-1:0] LAST_ENTRY = PALETTE_AW'(ENTRIES - 1);

    palette_wr_state_t     r_state;
    logic [PALETTE_AW-1:0] r_init_cnt;
    logic [PALETTE_AW-1:0] r_cpu_index;
    logic [7:0]            r_red;
    logic [7:0]            r_green;
    logic                  r_init_busy;
    logic                  r_wr_valid;
    logic [PALETTE_AW-1:0] r_wr_addr;
    palette_rgb_t          r_wr_data;
    logic                  r_lookup_blank;

    logic                  w_in_init;
    logic                  w_data_byte;
    logic                  w_ram_we;
    logic [PALETTE_AW-1:0] w_ram_waddr;
    palette_rgb_t          w_ram_wdata;
    palette_rgb_t          w_ram_rdata;
    palette_rgb_t          w_lookup;

    assign w_in_init   = (r_state == INIT);
    // An index write in the same cycle always wins over a data byte.
    assign w_data_byte = bus.cpu_data_wr && !bus.cpu_index_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_cpu_index <= '0;
            r_red       <= '0;
            r_green     <= '0;
            r_init_busy <= 1'b1;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            if (bus.cpu_index_wr) begin
                r_cpu_index <= bus.cpu_data;
                if (r_state != INIT) begin
                    r_state <= IDLE_R;
                end
            end
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_ENTRY) begin
                        r_state     <= IDLE_R;
                        r_init_busy <= 1'b0;
                    end
                end
                IDLE_R: begin
                    if (w_data_byte) begin
                        r_red   <= bus.cpu_data;
                        r_state <= WAIT_G;
                    end
                end
                WAIT_G: begin
                    if (w_data_byte) begin
                        r_green <= bus.cpu_data;
                        r_state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (w_data_byte) begin
                        r_wr_valid  <= 1'b1;
                        r_wr_addr   <= r_cpu_index;
                        r_wr_data   <= palette_rgb_t'{r: r_red, g: r_green, b: bus.cpu_data};
                        r_cpu_index <= r_cpu_index + 1'b1;
                        r_state     <= IDLE_R;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    // Tracks whether the lookup now in the RAM read register was sampled during INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lookup_blank <= 1'b1;
        end else begin
            r_lookup_blank <= w_in_init;
        end
    end

    assign w_ram_we    = w_in_init || r_wr_valid;
    assign w_ram_waddr = w_in_init ? r_init_cnt : r_wr_addr;
    assign w_ram_wdata = w_in_init ? init_colour(r_init_cnt, INIT_RAMP) : r_wr_data;

    vdp_palette_ram #(
        .DEPTH (PALETTE_ENTRIES)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (bus.palette_addr),
        .o_rdata (w_ram_rdata)
    );

    assign w_lookup      = r_lookup_blank ? palette_rgb_t'('0) : w_ram_rdata;
    assign bus.palette_r = w_lookup.r;
    assign bus.palette_g = w_lookup.g;
    assign bus.palette_b = w_lookup.b;
    assign bus.cpu_index = r_cpu_index;
    assign bus.init_busy = r_init_busy;

endmodule

// File: tb/tb_vdp_super_palette.sv
// Directed bench for vdp_super_palette: lookups are scoreboarded, status is checked inline.
module tb_vdp_super_palette;
    import vdp_super_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vdp_super_palette_if bus();

    vdp_super_palette #(
        .ENTRIES   (256),
        .INIT_RAMP (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] exp;
    } look_t;

    look_t       sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        look_req = 1'b0;
    logic        look_pending = 1'b0;
    look_t       mon_e;
    logic [23:0] mon_got;

    // Monitor: the lookup issued before an edge is presented until the next edge.
    always @(posedge clk) look_pending <= look_req;

    always @(negedge clk) begin
        if (look_pending) begin
            n_cmp++;
            mon_got = {bus.palette_r, bus.palette_g, bus.palette_b};
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL lookup: got %h with no expected entry queued", mon_got);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_got !== mon_e.exp) begin
                    n_err++;
                    $display("FAIL lookup addr=%h: got %h want %h", mon_e.addr, mon_got, mon_e.exp);
                end else begin
                    $display("lookup addr=%h: got %h ok", mon_e.addr, mon_got);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end else begin
            $display("%s: got %h ok", name, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_idx(input logic [7:0] v);
        bus.cpu_index_wr = 1'b1;
        bus.cpu_data     = v;
        @(negedge clk);
        bus.cpu_index_wr = 1'b0;
    endtask

    task automatic cpu_byte(input logic [7:0] v);
        bus.cpu_data_wr = 1'b1;
        bus.cpu_data    = v;
        @(negedge clk);
        bus.cpu_data_wr = 1'b0;
    endtask

    task automatic cpu_both(input logic [7:0] v);
        bus.cpu_index_wr = 1'b1;
        bus.cpu_data_wr  = 1'b1;
        bus.cpu_data     = v;
        @(negedge clk);
        bus.cpu_index_wr = 1'b0;
        bus.cpu_data_wr  = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] a, input logic [23:0] exp);
        bus.palette_addr = a;
        look_req         = 1'b1;
        sb_q.push_back(look_t'{addr: a, exp: exp});
        @(negedge clk);
        look_req = 1'b0;
    endtask

    task automatic wait_init();
        int cnt;
        cnt = 0;
        while (bus.init_busy === 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("init_busy clocks", cnt, 256);
    endtask

    initial begin
        reset            = 1'b1;
        bus.palette_addr = '0;
        bus.cpu_index_wr = 1'b0;
        bus.cpu_data_wr  = 1'b0;
        bus.cpu_data     = '0;
        repeat (3) @(negedge clk);
        check("reset palette rgb", {8'h0, bus.palette_r, bus.palette_g, bus.palette_b}, 32'h0);
        check("reset cpu_index", bus.cpu_index, 32'h0);
        check("reset init_busy", bus.init_busy, 32'h1);
        reset = 1'b0;

        // Early INIT: lookups blank, index writes accepted; then reset after ~100 clocks.
        idle(5);
        lookup(8'h05, 24'h000000);
        cpu_idx(8'h33);
        check("init cpu_index", bus.cpu_index, 32'h33);
        check("init busy mid", bus.init_busy, 32'h1);
        idle(92);
        reset = 1'b1;
        @(negedge clk);
        check("midinit reset cpu_index", bus.cpu_index, 32'h0);
        check("midinit reset busy", bus.init_busy, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        wait_init();

        lookup(8'hFF, 24'hFFFFFF);
        lookup(8'h80, 24'h808080);

        // Basic write
        cpu_idx(8'h10);
        cpu_byte(8'h12); cpu_byte(8'h34); cpu_byte(8'h56);
        idle(1);
        lookup(8'h10, 24'h123456);
        check("basic cpu_index", bus.cpu_index, 32'h11);

        // Collision: first lookup shares the edge with the RAM write
        cpu_idx(8'h40);
        cpu_byte(8'hA1); cpu_byte(8'hB2); cpu_byte(8'hC3);
        lookup(8'h40, 24'h404040);
        lookup(8'h40, 24'hA1B2C3);

        // Index wrap with back-to-back bytes
        cpu_idx(8'hFF);
        cpu_byte(8'h11); cpu_byte(8'h22); cpu_byte(8'h33);
        cpu_byte(8'h44); cpu_byte(8'h55); cpu_byte(8'h66);
        idle(1);
        lookup(8'hFF, 24'h112233);
        lookup(8'h00, 24'h445566);
        check("wrap cpu_index", bus.cpu_index, 32'h01);

        // Abort a partial sequence
        cpu_idx(8'h20);
        cpu_byte(8'hAA); cpu_byte(8'hBB);
        cpu_idx(8'h30);
        cpu_byte(8'h01); cpu_byte(8'h02); cpu_byte(8'h03);
        idle(1);
        lookup(8'h20, 24'h202020);
        lookup(8'h30, 24'h010203);
        check("abort cpu_index", bus.cpu_index, 32'h31);

        // Index and data strobes together: index wins, byte dropped
        cpu_idx(8'h60);
        cpu_byte(8'h11);
        cpu_both(8'h70);
        cpu_byte(8'h7A); cpu_byte(8'h7B); cpu_byte(8'h7C);
        idle(1);
        lookup(8'h70, 24'h7A7B7C);
        lookup(8'h60, 24'h606060);
        check("both cpu_index", bus.cpu_index, 32'h71);

        // Reset after the G byte: sequence lost, INIT reruns in full
        cpu_idx(8'h90);
        cpu_byte(8'h91); cpu_byte(8'h92);
        reset = 1'b1;
        @(negedge clk);
        check("midseq reset cpu_index", bus.cpu_index, 32'h0);
        check("midseq reset rgb", {8'h0, bus.palette_r, bus.palette_g, bus.palette_b}, 32'h0);
        check("midseq reset busy", bus.init_busy, 32'h1);
        reset = 1'b0;
        wait_init();
        lookup(8'h90, 24'h909090);
        lookup(8'h10, 24'h101010);
        cpu_byte(8'h93);
        idle(1);
        lookup(8'h00, 24'h000000);
        check("post reset cpu_index", bus.cpu_index, 32'h0);

        idle(3);
        check("scoreboard drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
